calc_key_entry: RTL and testbench

- Operand-entry controller directly upstream of the calculator ALU.
- Takes debounced single-cycle keypad events and assembles two 4-digit BCD operands plus an operation code.
- Drives the ALU operand/op inputs and a display word; consumes the ALU result and sign flag for result display and chained calculations.
- ALU is combinational; this block holds operands stable while a result is shown.

---
 rtl/calc_key_entry.sv | 158 +++++++++++++++
 tb/tb_calc_key_entry.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - keypad operand-entry controller feeding the calculator ALU
module calc_key_entry #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic [4*NDIG-1:0]   alu_result,
    input  logic                alu_neg,
    output logic [4*NDIG-1:0]   bcd1,
    output logic [4*NDIG-1:0]   bcd2,
    output logic [1:0]          op_selected,
    output logic [4*NDIG-1:0]   display,
    output logic                disp_neg,
    output logic                result_valid,
    output logic                entry_full
);

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    localparam logic [3:0] K_ADD = 4'hA;
    localparam logic [3:0] K_SUB = 4'hB;
    localparam logic [3:0] K_EQ  = 4'hC;
    localparam logic [3:0] K_CE  = 4'hD;
    localparam logic [3:0] K_AC  = 4'hE;

    typedef enum logic [1:0] {
        ST_ENTER_A,
        ST_OP_WAIT,
        ST_ENTER_B,
        ST_RESULT
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_bcd1;
    logic [W-1:0]    r_bcd2;
    logic [1:0]      r_op;
    logic [CW-1:0]   r_count;

    logic            w_is_digit;
    logic            w_is_op;
    logic [1:0]      w_op_code;
    logic            w_room;
    logic [W-1:0]    w_digit_ext;
    logic [W-1:0]    w_shift_a;
    logic [W-1:0]    w_shift_b;

    assign w_is_digit  = (key_code <= 4'd9);
    assign w_is_op     = (key_code == K_ADD) || (key_code == K_SUB);
    assign w_op_code   = (key_code == K_ADD) ? 2'b01 : 2'b10;
    assign w_room      = (r_count < CW'(NDIG));
    assign w_digit_ext = {{(W-4){1'b0}}, key_code};
    assign w_shift_a   = {r_bcd1[W-5:0], key_code};
    assign w_shift_b   = {r_bcd2[W-5:0], key_code};

    // Entry state machine: operands, operator and digit count update on accepted keys
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state <= ST_ENTER_A;
            r_bcd1  <= '0;
            r_bcd2  <= '0;
            r_op    <= 2'b00;
            r_count <= '0;
        end else if (key_valid) begin
            if (key_code == K_AC) begin
                r_state <= ST_ENTER_A;
                r_bcd1  <= '0;
                r_bcd2  <= '0;
                r_op    <= 2'b00;
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_ENTER_A: begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                r_bcd1  <= w_shift_a;
                                r_count <= r_count + 1'b1;
                            end
                        end else if (w_is_op) begin
                            r_op    <= w_op_code;
                            r_count <= '0;
                            r_state <= ST_OP_WAIT;
                        end else if (key_code == K_CE) begin
                            r_bcd1  <= '0;
                            r_count <= '0;
                        end
                    end
                    ST_OP_WAIT: begin
                        if (w_is_digit) begin
                            r_bcd2  <= w_digit_ext;
                            r_count <= CW'(1);
                            r_state <= ST_ENTER_B;
                        end else if (w_is_op) begin
                            r_op <= w_op_code;
                        end
                    end
                    ST_ENTER_B: begin
                        if (w_is_digit) begin
                            if (w_room) begin
                                r_bcd2  <= w_shift_b;
                                r_count <= r_count + 1'b1;
                            end
                        end else if (key_code == K_EQ) begin
                            r_state <= ST_RESULT;
                        end else if (key_code == K_CE) begin
                            r_bcd2  <= '0;
                            r_count <= '0;
                        end
                    end
                    ST_RESULT: begin
                        if (w_is_digit) begin
                            r_bcd1  <= w_digit_ext;
                            r_bcd2  <= '0;
                            r_op    <= 2'b00;
                            r_count <= CW'(1);
                            r_state <= ST_ENTER_A;
                        end else if (w_is_op && !alu_neg) begin
                            // Chaining: a non-negative result becomes the new first operand
                            r_bcd1  <= alu_result;
                            r_bcd2  <= '0;
                            r_op    <= w_op_code;
                            r_count <= '0;
                            r_state <= ST_OP_WAIT;
                        end else if (key_code == K_CE) begin
                            r_state <= ST_ENTER_A;
                            r_bcd1  <= '0;
                            r_bcd2  <= '0;
                            r_op    <= 2'b00;
                            r_count <= '0;
                        end
                    end
                    default: r_state <= ST_ENTER_A;
                endcase
            end
        end
    end

    // Display source: operand being worked on, or the ALU result while it is shown
    always_comb begin
        display = r_bcd1;
        case (r_state)
            ST_ENTER_B: display = r_bcd2;
            ST_RESULT:  display = alu_result;
            default:    display = r_bcd1;
        endcase
    end

    assign bcd1         = r_bcd1;
    assign bcd2         = r_bcd2;
    assign op_selected  = r_op;
    assign result_valid = (r_state == ST_RESULT);
    assign disp_neg     = (r_state == ST_RESULT) && alu_neg;
    assign entry_full   = (r_count == CW'(NDIG)) &&
                          ((r_state == ST_ENTER_A) || (r_state == ST_ENTER_B));

endmodule

// File: tb/tb_calc_key_entry.sv
// tb/tb_calc_key_entry.sv - self-checking bench for calc_key_entry
module tb_calc_key_entry;

    logic        clk;
    logic        clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_result;
    logic        alu_neg;
    logic [15:0] bcd1;
    logic [15:0] bcd2;
    logic [1:0]  op_selected;
    logic [15:0] display;
    logic        disp_neg;
    logic        result_valid;
    logic        entry_full;

    int n_checks = 0;
    int n_fail   = 0;

    calc_key_entry #(.NDIG(4)) dut (
        .clk          (clk),
        .clear        (clear),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .alu_result   (alu_result),
        .alu_neg      (alu_neg),
        .bcd1         (bcd1),
        .bcd2         (bcd2),
        .op_selected  (op_selected),
        .display      (display),
        .disp_neg     (disp_neg),
        .result_valid (result_valid),
        .entry_full   (entry_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] b1;
        logic [15:0] b2;
        logic [1:0]  op;
        logic [15:0] disp;
        logic        neg;
        logic        rv;
        logic        ef;
    } outs_t;

    typedef struct {
        logic [3:0] key;
        outs_t      exp;
    } vec_t;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        return 1000 * int'(b[15:12]) + 100 * int'(b[11:8]) + 10 * int'(b[7:4]) + int'(b[3:0]);
    endfunction

    // Signed arithmetic result of the calculator operation
    function automatic int alu_val(input int a, input int b, input int op);
        if (op == 1) return a + b;
        if (op == 2) return a - b;
        return 0;
    endfunction

    function automatic int alu_mag(input int r);
        return ((r < 0) ? -r : r) % 10000;
    endfunction

    // Behavioural ALU driven from the DUT operands
    always_comb begin
        int r;
        r = alu_val(from_bcd(bcd1), from_bcd(bcd2), int'(op_selected));
        alu_neg    = (r < 0);
        alu_result = to_bcd(alu_mag(r));
    end

    // Reference model: phase 0 enter A, 1 op wait, 2 enter B, 3 result
    int m_phase, m_a, m_b, m_op, m_cnt;

    function automatic void model_reset();
        m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
    endfunction

    function automatic void model_key(input int k);
        int r;
        bit is_dig, is_op;
        int newop;
        r      = alu_val(m_a, m_b, m_op);
        is_dig = (k <= 9);
        is_op  = (k == 10) || (k == 11);
        newop  = (k == 10) ? 1 : 2;
        if (k == 14) begin
            model_reset();
            return;
        end
        case (m_phase)
            0: begin
                if (is_dig && m_cnt < 4) begin m_a = m_a * 10 + k; m_cnt++; end
                else if (is_op) begin m_op = newop; m_cnt = 0; m_phase = 1; end
                else if (k == 13) begin m_a = 0; m_cnt = 0; end
            end
            1: begin
                if (is_dig) begin m_b = k; m_cnt = 1; m_phase = 2; end
                else if (is_op) m_op = newop;
            end
            2: begin
                if (is_dig && m_cnt < 4) begin m_b = m_b * 10 + k; m_cnt++; end
                else if (k == 12) m_phase = 3;
                else if (k == 13) begin m_b = 0; m_cnt = 0; end
            end
            default: begin
                if (is_dig) begin m_a = k; m_b = 0; m_op = 0; m_cnt = 1; m_phase = 0; end
                else if (is_op && r >= 0) begin
                    m_a = alu_mag(r); m_b = 0; m_op = newop; m_cnt = 0; m_phase = 1;
                end
                else if (k == 13) model_reset();
            end
        endcase
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        int r;
        r      = alu_val(m_a, m_b, m_op);
        o.b1   = to_bcd(m_a);
        o.b2   = to_bcd(m_b);
        o.op   = 2'(m_op);
        o.disp = (m_phase == 3) ? to_bcd(alu_mag(r)) : (m_phase == 2) ? to_bcd(m_b) : to_bcd(m_a);
        o.neg  = (m_phase == 3) && (r < 0);
        o.rv   = (m_phase == 3);
        o.ef   = (m_cnt == 4) && (m_phase == 0 || m_phase == 2);
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.b1 = bcd1; o.b2 = bcd2; o.op = op_selected; o.disp = display;
        o.neg = disp_neg; o.rv = result_valid; o.ef = entry_full;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = dut_outs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual bcd1=%h bcd2=%h op=%b disp=%h neg=%b rv=%b ef=%b, required bcd1=%h bcd2=%h op=%b disp=%h neg=%b rv=%b ef=%b",
                     name, act.b1, act.b2, act.op, act.disp, act.neg, act.rv, act.ef,
                     exp.b1, exp.b2, exp.op, exp.disp, exp.neg, exp.rv, exp.ef);
        end
    endtask

    task automatic apply(input logic [3:0] k, input bit valid);
        @(negedge clk);
        key_valid = valid;
        key_code  = k;
        if (valid) model_key(int'(k));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        check("async_reset", model_outs());
        @(negedge clk);
        clear = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] k, input logic [15:0] b1, input logic [15:0] b2,
                                input logic [1:0] op, input logic [15:0] d, input logic n,
                                input logic rv, input logic ef);
        vec_t v;
        v.key = k;
        v.exp = '{b1: b1, b2: b2, op: op, disp: d, neg: n, rv: rv, ef: ef};
        return v;
    endfunction

    vec_t tbl[$];
    outs_t zero_o;

    initial begin
        clear     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        zero_o    = '0;
        model_reset();

        // 123 + 45 = 168
        tbl.push_back(mk(4'h1, 16'h0001, 16'h0000, 2'b00, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(4'h2, 16'h0012, 16'h0000, 2'b00, 16'h0012, 0, 0, 0));
        tbl.push_back(mk(4'h3, 16'h0123, 16'h0000, 2'b00, 16'h0123, 0, 0, 0));
        tbl.push_back(mk(4'hA, 16'h0123, 16'h0000, 2'b01, 16'h0123, 0, 0, 0));
        tbl.push_back(mk(4'h4, 16'h0123, 16'h0004, 2'b01, 16'h0004, 0, 0, 0));
        tbl.push_back(mk(4'h5, 16'h0123, 16'h0045, 2'b01, 16'h0045, 0, 0, 0));
        tbl.push_back(mk(4'hC, 16'h0123, 16'h0045, 2'b01, 16'h0168, 0, 1, 0));
        tbl.push_back(mk(4'hE, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        // full entry, fifth digit dropped, CE
        tbl.push_back(mk(4'h1, 16'h0001, 16'h0000, 2'b00, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(4'h2, 16'h0012, 16'h0000, 2'b00, 16'h0012, 0, 0, 0));
        tbl.push_back(mk(4'h3, 16'h0123, 16'h0000, 2'b00, 16'h0123, 0, 0, 0));
        tbl.push_back(mk(4'h4, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(4'h5, 16'h1234, 16'h0000, 2'b00, 16'h1234, 0, 0, 1));
        tbl.push_back(mk(4'hD, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        // 7 - 9 = -2, op ignored on negative, digit restarts
        tbl.push_back(mk(4'h7, 16'h0007, 16'h0000, 2'b00, 16'h0007, 0, 0, 0));
        tbl.push_back(mk(4'hB, 16'h0007, 16'h0000, 2'b10, 16'h0007, 0, 0, 0));
        tbl.push_back(mk(4'h9, 16'h0007, 16'h0009, 2'b10, 16'h0009, 0, 0, 0));
        tbl.push_back(mk(4'hC, 16'h0007, 16'h0009, 2'b10, 16'h0002, 1, 1, 0));
        tbl.push_back(mk(4'hA, 16'h0007, 16'h0009, 2'b10, 16'h0002, 1, 1, 0));
        tbl.push_back(mk(4'h3, 16'h0003, 16'h0000, 2'b00, 16'h0003, 0, 0, 0));
        // chaining 5+5=10, then 10-3=7
        tbl.push_back(mk(4'hE, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'h5, 16'h0005, 16'h0000, 2'b00, 16'h0005, 0, 0, 0));
        tbl.push_back(mk(4'hA, 16'h0005, 16'h0000, 2'b01, 16'h0005, 0, 0, 0));
        tbl.push_back(mk(4'h5, 16'h0005, 16'h0005, 2'b01, 16'h0005, 0, 0, 0));
        tbl.push_back(mk(4'hC, 16'h0005, 16'h0005, 2'b01, 16'h0010, 0, 1, 0));
        tbl.push_back(mk(4'hB, 16'h0010, 16'h0000, 2'b10, 16'h0010, 0, 0, 0));
        tbl.push_back(mk(4'h3, 16'h0010, 16'h0003, 2'b10, 16'h0003, 0, 0, 0));
        tbl.push_back(mk(4'hC, 16'h0010, 16'h0003, 2'b10, 16'h0007, 0, 1, 0));
        // op with no digits, op replace, ignored keys, CE in B, CE in RESULT
        tbl.push_back(mk(4'hE, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'hA, 16'h0000, 16'h0000, 2'b01, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'hB, 16'h0000, 16'h0000, 2'b10, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'hC, 16'h0000, 16'h0000, 2'b10, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'hD, 16'h0000, 16'h0000, 2'b10, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'hF, 16'h0000, 16'h0000, 2'b10, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'h4, 16'h0000, 16'h0004, 2'b10, 16'h0004, 0, 0, 0));
        tbl.push_back(mk(4'hA, 16'h0000, 16'h0004, 2'b10, 16'h0004, 0, 0, 0));
        tbl.push_back(mk(4'hD, 16'h0000, 16'h0000, 2'b10, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'h6, 16'h0000, 16'h0006, 2'b10, 16'h0006, 0, 0, 0));
        tbl.push_back(mk(4'hC, 16'h0000, 16'h0006, 2'b10, 16'h0006, 1, 1, 0));
        tbl.push_back(mk(4'hC, 16'h0000, 16'h0006, 2'b10, 16'h0006, 1, 1, 0));
        tbl.push_back(mk(4'hD, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        // full B operand, chain on positive result, reserved key
        tbl.push_back(mk(4'h1, 16'h0001, 16'h0000, 2'b00, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(4'hA, 16'h0001, 16'h0000, 2'b01, 16'h0001, 0, 0, 0));
        tbl.push_back(mk(4'h9, 16'h0001, 16'h0009, 2'b01, 16'h0009, 0, 0, 0));
        tbl.push_back(mk(4'h8, 16'h0001, 16'h0098, 2'b01, 16'h0098, 0, 0, 0));
        tbl.push_back(mk(4'h7, 16'h0001, 16'h0987, 2'b01, 16'h0987, 0, 0, 0));
        tbl.push_back(mk(4'h6, 16'h0001, 16'h9876, 2'b01, 16'h9876, 0, 0, 1));
        tbl.push_back(mk(4'h5, 16'h0001, 16'h9876, 2'b01, 16'h9876, 0, 0, 1));
        tbl.push_back(mk(4'hC, 16'h0001, 16'h9876, 2'b01, 16'h9877, 0, 1, 0));
        tbl.push_back(mk(4'hB, 16'h9877, 16'h0000, 2'b10, 16'h9877, 0, 0, 0));
        tbl.push_back(mk(4'hF, 16'h9877, 16'h0000, 2'b10, 16'h9877, 0, 0, 0));
        tbl.push_back(mk(4'hE, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        // leading zeros count toward a full entry
        tbl.push_back(mk(4'h0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'h0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'h0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(4'h0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(4'h5, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(4'hE, 16'h0000, 16'h0000, 2'b00, 16'h0000, 0, 0, 0));

        #12;
        check("reset_state", zero_o);
        @(negedge clk);
        clear = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].key, 1'b1);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Idle cycles with a stray key code must hold
        apply(4'h1, 1'b1);
        apply(4'h7, 1'b0);
        check("idle_hold", model_outs());

        // Async reset mid-cycle while entering B = 0042
        apply(4'hE, 1'b1);
        apply(4'h1, 1'b1);
        apply(4'hA, 1'b1);
        apply(4'h4, 1'b1);
        apply(4'h2, 1'b1);
        check("enter_b_0042", model_outs());
        async_reset();
        apply(4'h0, 1'b0);
        check("after_async_reset", zero_o);

        // AC from RESULT
        apply(4'h1, 1'b1);
        apply(4'hA, 1'b1);
        apply(4'h2, 1'b1);
        apply(4'hC, 1'b1);
        check("result_1p2", model_outs());
        apply(4'hE, 1'b1);
        check("ac_from_result", zero_o);

        // Randomized keys against the reference model
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                logic [3:0] k;
                bit v;
                v = ($urandom_range(0, 3) != 0);
                k = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
                apply(k, v);
                check("random", model_outs());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
